// File: rtl/arb2_sel.sv
// arb2_sel: two-channel round-robin arbiter feeding a single registered output slot.
// A word is captured from the winning channel whenever the slot is empty or is being
// drained in the same cycle, giving one word per cycle under continuous out_ready.
// The registered sel output drives the downstream 2:1 mux select.
//
// Optional build macro: ARB2_SEL_STATS_EN
//   Defined   - adds cnt0/cnt1, 16-bit saturating per-channel capture counters.
//   Undefined - counters and their ports are absent; behaviour is otherwise identical.

module arb2_sel #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic             out_ready,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
`ifdef ARB2_SEL_STATS_EN
    ,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1
`else
    // No statistics ports in this build.
`endif
);

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StHold = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic             sel_q, sel_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;

    logic             any_req;
    logic             slot_free;
    logic             capture;
    logic             winner;
    logic [WIDTH-1:0] win_data;

    // Arbitration: lone requester wins; on contention the priority pointer decides.
    always_comb begin
        any_req   = req0 | req1;
        slot_free = (state_q == StIdle) || ((state_q == StHold) && out_ready);
        capture   = slot_free && any_req;
        if (req0 && req1) begin
            winner = prio_q;
        end else begin
            winner = req1;
        end
        win_data = winner ? data1 : data0;
    end

    // Next-state and datapath update for the output slot.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        sel_d       = sel_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (capture) begin
                    state_d     = StHold;
                    out_valid_d = 1'b1;
                    out_data_d  = win_data;
                    sel_d       = winner;
                    prio_d      = ~winner;
                    gnt0_d      = ~winner;
                    gnt1_d      = winner;
                end
            end
            StHold: begin
                if (out_ready) begin
                    if (capture) begin
                        // Drain and refill in the same cycle: slot stays valid.
                        out_valid_d = 1'b1;
                        out_data_d  = win_data;
                        sel_d       = winner;
                        prio_d      = ~winner;
                        gnt0_d      = ~winner;
                        gnt1_d      = winner;
                    end else begin
                        // Slot drained; data and sel keep their last values.
                        state_d     = StIdle;
                        out_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = StIdle;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Output slot, priority pointer and grant pulses; reset drops any held word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prio_q      <= 1'b0;
            sel_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign sel       = sel_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef ARB2_SEL_STATS_EN
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    // Saturating per-channel capture counters.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (capture && !winner && (cnt0_q != 16'hFFFF)) begin
            cnt0_d = cnt0_q + 16'd1;
        end
        if (capture && winner && (cnt1_q != 16'hFFFF)) begin
            cnt1_d = cnt1_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    // Statistics counters not built.
`endif

endmodule
